// File: rtl/wb_stage_pkg.sv
// Shared types and constants for the writeback stage and its load formatter.
package wb_stage_pkg;

  localparam int XLEN_DEF   = 64;
  localparam int REG_ADDR_W = 5;

  // Load-size encodings carried in funct3
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // One buffered writeback: enable, destination, final data
  typedef struct packed {
    logic                  we;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN_DEF-1:0]   data;
  } wb_entry;

  // x0 is hardwired, so a write to it is never a real write
  function automatic logic isRealWrite(input logic regWr,
                                       input logic [REG_ADDR_W-1:0] rd);
    return regWr && (rd != '0);
  endfunction

endpackage

// File: rtl/wb_stage_load_extend.sv
// load_extend: picks the ALU result or a size/sign-formatted load value.
// Purely combinational so the MEM stage can reuse it as-is.
module load_extend
  import wb_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            memToReg,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] aluResult,
  input  logic [XLEN-1:0] loadData,
  output logic [XLEN-1:0] result
);

  // Select source, then extract and extend by load size; 111 behaves as LD
  always_comb begin
    result = aluResult;
    if (memToReg) begin
      case (funct3)
        F3_LB:   result = {{(XLEN-8){loadData[7]}},   loadData[7:0]};
        F3_LH:   result = {{(XLEN-16){loadData[15]}}, loadData[15:0]};
        F3_LW:   result = {{(XLEN-32){loadData[31]}}, loadData[31:0]};
        F3_LBU:  result = {{(XLEN-8){1'b0}},          loadData[7:0]};
        F3_LHU:  result = {{(XLEN-16){1'b0}},         loadData[15:0]};
        F3_LWU:  result = {{(XLEN-32){1'b0}},         loadData[31:0]};
        default: result = loadData;
      endcase
    end
  end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: writeback buffer in front of the register file write port.
// Results are formatted at push, queued in a DEPTH-entry FIFO and popped
// into registered regWrite/writeReg/writeData. Forwarding exposes every
// pending write (FIFO plus output register) to the two decode read ports.
// Optional: define WB_PERF_CNT_EN to add perf_retired / perf_stall counters.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_reg_write,
  input  logic                  in_mem_to_reg,
  input  logic [2:0]            in_funct3,
  input  logic [XLEN-1:0]       in_alu_result,
  input  logic [XLEN-1:0]       in_load_data,
  input  logic                  wb_stall,
  output logic                  regWrite,
  output logic [REG_ADDR_W-1:0] writeReg,
  output logic [XLEN-1:0]       writeData,
  input  logic [REG_ADDR_W-1:0] fwd_rs1,
  input  logic [REG_ADDR_W-1:0] fwd_rs2,
  output logic                  fwd_hit1,
  output logic                  fwd_hit2,
  output logic [XLEN-1:0]       fwd_data1,
  output logic [XLEN-1:0]       fwd_data2
`ifdef WB_PERF_CNT_EN
  ,
  output logic [63:0]           perf_retired,
  output logic [63:0]           perf_stall
`endif
);

  localparam int           PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0]  DEPTH_C = (PW+1)'(DEPTH);
  localparam int           NPORT   = 2;

  wb_entry         fifo [DEPTH];
  logic [PW-1:0]   wrPtr, rdPtr;
  logic [PW:0]     count;
  logic            pushEn, popEn;
  logic [XLEN-1:0] fmtData;
  wb_entry         newEntry, head;

  // Full FIFO never accepts, even when a pop frees a slot this cycle
  assign in_ready = (count < DEPTH_C);
  assign pushEn   = in_valid && in_ready;
  assign popEn    = (count != '0) && !wb_stall;
  assign head     = fifo[rdPtr];

  load_extend #(.XLEN(XLEN)) u_ext (
    .memToReg  (in_mem_to_reg),
    .funct3    (in_funct3),
    .aluResult (in_alu_result),
    .loadData  (in_load_data),
    .result    (fmtData)
  );

  // x0 targets still occupy a slot so ordering is kept, but never write
  always_comb begin
    newEntry      = '0;
    newEntry.we   = isRealWrite(in_reg_write, in_rd);
    newEntry.rd   = in_rd;
    newEntry.data = fmtData;
  end

  // FIFO storage, pointers (wrap naturally at power-of-two DEPTH) and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
    end else begin
      if (pushEn) begin
        fifo[wrPtr] <= newEntry;
        wrPtr       <= wrPtr + 1'b1;
      end
      if (popEn) rdPtr <= rdPtr + 1'b1;
      case ({pushEn, popEn})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Register-file write port: load head on pop, otherwise drop the enable only
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regWrite  <= 1'b0;
      writeReg  <= '0;
      writeData <= '0;
    end else if (popEn) begin
      regWrite  <= head.we;
      writeReg  <= head.rd;
      writeData <= head.data;
    end else begin
      regWrite  <= 1'b0;
    end
  end

  logic [NPORT-1:0][REG_ADDR_W-1:0] fwdAddr;
  logic [NPORT-1:0]                 fwdHit;
  logic [NPORT-1:0][XLEN-1:0]       fwdData;
  logic [PW-1:0]                    idx;

  assign fwdAddr = {fwd_rs2, fwd_rs1};

  // Scan oldest to youngest (output reg, then FIFO head..tail); last match wins
  always_comb begin
    fwdHit  = '0;
    fwdData = '0;
    idx     = '0;
    for (int p = 0; p < NPORT; p++) begin
      if (regWrite && (writeReg == fwdAddr[p])) begin
        fwdHit[p]  = 1'b1;
        fwdData[p] = writeData;
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = rdPtr + PW'(i);
        if (((PW+1)'(i) < count) && fifo[idx].we && (fifo[idx].rd == fwdAddr[p])) begin
          fwdHit[p]  = 1'b1;
          fwdData[p] = fifo[idx].data;
        end
      end
      // we is already clear for x0; this keeps the port quiet regardless
      if (fwdAddr[p] == '0) begin
        fwdHit[p]  = 1'b0;
        fwdData[p] = '0;
      end
    end
  end

  assign fwd_hit1  = fwdHit[0];
  assign fwd_hit2  = fwdHit[1];
  assign fwd_data1 = fwdData[0];
  assign fwd_data2 = fwdData[1];

`ifdef WB_PERF_CNT_EN
  // Retired real writes and stalled-with-work cycles; both wrap at 2^64
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_retired <= '0;
      perf_stall   <= '0;
    end else begin
      if (popEn && head.we)             perf_retired <= perf_retired + 64'd1;
      if ((count != '0) && wb_stall)    perf_stall   <= perf_stall + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_wb_stage;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [4:0]  in_rd = '0;
  logic        in_reg_write = 1'b0, in_mem_to_reg = 1'b0;
  logic [2:0]  in_funct3 = '0;
  logic [63:0] in_alu_result = '0, in_load_data = '0;
  logic        wb_stall = 1'b0;
  logic        regWrite;
  logic [4:0]  writeReg;
  logic [63:0] writeData;
  logic [4:0]  fwd_rs1 = '0, fwd_rs2 = '0;
  logic        fwd_hit1, fwd_hit2;
  logic [63:0] fwd_data1, fwd_data2;
`ifdef WB_PERF_CNT_EN
  logic [63:0] perf_retired, perf_stall;
`endif

  wb_stage #(.XLEN(64), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
    .in_funct3(in_funct3), .in_alu_result(in_alu_result), .in_load_data(in_load_data),
    .wb_stall(wb_stall), .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
    .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
`ifdef WB_PERF_CNT_EN
    , .perf_retired(perf_retired), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct { bit we; bit [4:0] rd; bit [63:0] data; } ent_t;
  ent_t      mq[$];
  bit        mRw;
  bit [4:0]  mWr;
  bit [63:0] mWd;

  // Load formatting from the ISA meaning of each funct3, via type casts and masks
  function automatic bit [63:0] ref_fmt(bit m2r, bit [2:0] f3, bit [63:0] alu, bit [63:0] ld);
    if (!m2r) return alu;
    case (f3)
      3'd0:    return longint'(byte'(ld[7:0]));
      3'd1:    return longint'(shortint'(ld[15:0]));
      3'd2:    return longint'(int'(ld[31:0]));
      3'd4:    return ld & 64'hFF;
      3'd5:    return ld & 64'hFFFF;
      3'd6:    return ld & 64'hFFFF_FFFF;
      default: return ld;
    endcase
  endfunction

  // Youngest pending write to addr: queue tail first, output register last
  function automatic void ref_fwd(input bit [4:0] a, output bit hit, output bit [63:0] d);
    hit = 0; d = 0;
    if (a == 0) return;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].we && mq[i].rd == a) begin hit = 1; d = mq[i].data; return; end
    if (mRw && mWr == a) begin hit = 1; d = mWd; end
  endfunction

  task automatic model_clear();
    mq.delete(); mRw = 0; mWr = 0; mWd = 0;
  endtask

  // One rising edge; model decides push/pop from the pre-edge inputs
  task automatic tick();
    bit doPush, doPop;
    ent_t e, h;
    doPush = in_valid && (mq.size() < DEPTH);
    doPop  = (mq.size() > 0) && !wb_stall;
    e.we   = in_reg_write && (in_rd != 0);
    e.rd   = in_rd;
    e.data = ref_fmt(in_mem_to_reg, in_funct3, in_alu_result, in_load_data);
    @(posedge clk); #1;
    if (doPop) begin h = mq.pop_front(); mRw = h.we; mWr = h.rd; mWd = h.data; end
    else mRw = 0;
    if (doPush) mq.push_back(e);
  endtask

  task automatic drive(bit v, bit [4:0] rd, bit we, bit m2r, bit [2:0] f3, bit [63:0] alu, bit [63:0] ld);
    in_valid = v; in_rd = rd; in_reg_write = we; in_mem_to_reg = m2r;
    in_funct3 = f3; in_alu_result = alu; in_load_data = ld;
  endtask

  task automatic idle(int n);
    in_valid = 0; wb_stall = 0;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    reset = 0; model_clear();
    #2;
    checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL reset_regWrite got=%0b exp=0", regWrite); end
    checks++; if (writeReg !== 5'd0) begin errors++; $display("FAIL reset_writeReg got=%0d exp=0", writeReg); end
    checks++; if (writeData !== 64'd0) begin errors++; $display("FAIL reset_writeData got=%h exp=0", writeData); end
    #1 reset = 1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    tick();
    checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL idle_regWrite got=%0b exp=0", regWrite); end
  endtask

  task automatic test_load_sign();
    drive(1, 5, 1, 0, 3'd0, 64'h1234, 64'h0);
    tick();
    checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL lat_early got=%0b exp=0", regWrite); end
    drive(1, 6, 1, 1, 3'd0, 64'h0, 64'h5555_0000_0000_0080);
    tick();
    checks++; if ({regWrite, writeReg, writeData} !== {1'b1, 5'd5, 64'h1234}) begin
      errors++; $display("FAIL alu_write got=%0b/%0d/%h exp=1/5/1234", regWrite, writeReg, writeData); end
    drive(1, 7, 1, 1, 3'd4, 64'h0, 64'h5555_0000_0000_0080);
    tick();
    checks++; if ({writeReg, writeData} !== {5'd6, 64'hFFFF_FFFF_FFFF_FF80}) begin
      errors++; $display("FAIL lb_sign got=%0d/%h exp=6/ffffffffffffff80", writeReg, writeData); end
    in_valid = 0;
    tick();
    checks++; if ({regWrite, writeData} !== {1'b1, 64'h80}) begin
      errors++; $display("FAIL lbu_zero got=%0b/%h exp=1/80", regWrite, writeData); end
    idle(1);
  endtask

  task automatic test_stall();
    wb_stall = 1;
    drive(1, 1, 1, 0, 3'd0, 64'h11, 0); tick();
    drive(1, 2, 1, 0, 3'd0, 64'h22, 0); tick();
    drive(1, 3, 1, 0, 3'd0, 64'h33, 0); #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%0b exp=0", in_ready); end
    tick();
    checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL stalled_write got=%0b exp=0", regWrite); end
    wb_stall = 0; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_no_passthru got=%0b exp=0", in_ready); end
    tick();
    checks++; if ({regWrite, writeReg} !== {1'b1, 5'd1}) begin
      errors++; $display("FAIL drain_1 got=%0b/%0d exp=1/1", regWrite, writeReg); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_after_pop got=%0b exp=1", in_ready); end
    tick();
    checks++; if ({regWrite, writeReg, writeData} !== {1'b1, 5'd2, 64'h22}) begin
      errors++; $display("FAIL drain_2 got=%0b/%0d/%h exp=1/2/22", regWrite, writeReg, writeData); end
    in_valid = 0; tick();
    checks++; if ({regWrite, writeReg, writeData} !== {1'b1, 5'd3, 64'h33}) begin
      errors++; $display("FAIL third_accepted got=%0b/%0d/%h exp=1/3/33", regWrite, writeReg, writeData); end
    idle(1);
  endtask

  task automatic test_x0();
    fwd_rs1 = 0;
    drive(1, 0, 1, 0, 3'd0, 64'hDEAD, 0); tick();
    in_valid = 0; #1;
    checks++; if ({fwd_hit1, fwd_data1} !== {1'b0, 64'h0}) begin
      errors++; $display("FAIL x0_fwd got=%0b/%h exp=0/0", fwd_hit1, fwd_data1); end
    tick();
    checks++; if ({regWrite, writeData} !== {1'b0, 64'hDEAD}) begin
      errors++; $display("FAIL x0_write got=%0b/%h exp=0/dead", regWrite, writeData); end
    idle(1);
  endtask

  task automatic test_fwd_priority();
    wb_stall = 1;
    drive(1, 7, 1, 0, 3'd0, 64'd1, 0); tick();
    drive(1, 7, 1, 0, 3'd0, 64'd2, 0); tick();
    in_valid = 0; fwd_rs1 = 7; fwd_rs2 = 8; #1;
    checks++; if ({fwd_hit1, fwd_data1} !== {1'b1, 64'd2}) begin
      errors++; $display("FAIL fwd_youngest got=%0b/%h exp=1/2", fwd_hit1, fwd_data1); end
    checks++; if ({fwd_hit2, fwd_data2} !== {1'b0, 64'd0}) begin
      errors++; $display("FAIL fwd_miss got=%0b/%h exp=0/0", fwd_hit2, fwd_data2); end
    wb_stall = 0; tick();
    checks++; if ({regWrite, writeData, fwd_hit1, fwd_data1} !== {1'b1, 64'd1, 1'b1, 64'd2}) begin
      errors++; $display("FAIL fwd_after_pop1 got=%0b/%h/%0b/%h exp=1/1/1/2", regWrite, writeData, fwd_hit1, fwd_data1); end
    tick();
    checks++; if ({regWrite, fwd_hit1, fwd_data1} !== {1'b1, 1'b1, 64'd2}) begin
      errors++; $display("FAIL fwd_outreg got=%0b/%0b/%h exp=1/1/2", regWrite, fwd_hit1, fwd_data1); end
    tick();
    checks++; if ({regWrite, fwd_hit1, fwd_data1} !== {1'b0, 1'b0, 64'd0}) begin
      errors++; $display("FAIL fwd_gone got=%0b/%0b/%h exp=0/0/0", regWrite, fwd_hit1, fwd_data1); end
  endtask

  task automatic test_reset_mid();
    wb_stall = 1;
    drive(1, 9, 1, 0, 3'd0, 64'h99, 0); tick();
    drive(1, 10, 1, 0, 3'd0, 64'hAA, 0); tick();
    in_valid = 0; wb_stall = 0; fwd_rs1 = 10; tick();
    checks++; if ({regWrite, fwd_hit1} !== 2'b11) begin
      errors++; $display("FAIL pre_reset got=%0b/%0b exp=1/1", regWrite, fwd_hit1); end
    #2 reset = 0; #1;
    checks++; if ({regWrite, in_ready, fwd_hit1} !== 3'b010) begin
      errors++; $display("FAIL mid_reset got=%0b/%0b/%0b exp=0/1/0", regWrite, in_ready, fwd_hit1); end
    model_clear();
    #1 reset = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL lost_write cyc=%0d got=%0b exp=0", i, regWrite); end
    end
  endtask

  task automatic test_back_to_back();
    bit [63:0] d [10];
    wb_stall = 0;
    for (int i = 0; i < 10; i++) begin
      d[i] = {$urandom, $urandom};
      drive(1, 5'(i + 1), 1, 0, 3'd0, d[i], 0); #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready i=%0d got=%0b exp=1", i, in_ready); end
      tick();
      if (i > 0) begin
        checks++; if ({regWrite, writeReg, writeData} !== {1'b1, 5'(i), d[i-1]}) begin
          errors++; $display("FAIL b2b_write i=%0d got=%0b/%0d/%h exp=1/%0d/%h", i, regWrite, writeReg, writeData, i, d[i-1]); end
      end
    end
    in_valid = 0; tick();
    checks++; if ({regWrite, writeReg, writeData} !== {1'b1, 5'd10, d[9]}) begin
      errors++; $display("FAIL b2b_last got=%0b/%0d/%h exp=1/10/%h", regWrite, writeReg, writeData, d[9]); end
    idle(1);
  endtask

  task automatic test_random();
    bit h1, h2;
    bit [63:0] d1, d2;
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom_range(0, 4) != 0,
            1'($urandom), 3'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
      wb_stall = ($urandom_range(0, 3) == 0);
      fwd_rs1 = 5'($urandom_range(0, 7));
      fwd_rs2 = 5'($urandom_range(0, 7));
      #1;
      ref_fwd(fwd_rs1, h1, d1);
      ref_fwd(fwd_rs2, h2, d2);
      checks++; if (in_ready !== (mq.size() < DEPTH)) begin
        errors++; $display("FAIL rnd_ready n=%0d got=%0b exp=%0b", n, in_ready, mq.size() < DEPTH); end
      checks++; if ({fwd_hit1, fwd_data1} !== {h1, d1}) begin
        errors++; $display("FAIL rnd_fwd1 n=%0d rs=%0d got=%0b/%h exp=%0b/%h", n, fwd_rs1, fwd_hit1, fwd_data1, h1, d1); end
      checks++; if ({fwd_hit2, fwd_data2} !== {h2, d2}) begin
        errors++; $display("FAIL rnd_fwd2 n=%0d rs=%0d got=%0b/%h exp=%0b/%h", n, fwd_rs2, fwd_hit2, fwd_data2, h2, d2); end
      tick();
      checks++; if ({regWrite, writeReg, writeData} !== {mRw, mWr, mWd}) begin
        errors++; $display("FAIL rnd_wport n=%0d got=%0b/%0d/%h exp=%0b/%0d/%h", n, regWrite, writeReg, writeData, mRw, mWr, mWd); end
    end
    idle(3);
  endtask

  initial begin
    test_reset();
    test_load_sign();
    test_stall();
    test_x0();
    test_fwd_priority();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage directly upstream of the 64-bit, 32-entry register file.
- Accepts completed instructions from the MEM stage through a valid/ready handshake.
- Formats load data (size and sign extension), buffers results in a small FIFO, and drives the register file's single write port (regWrite/writeReg/writeData) from registered outputs.
- Provides forwarding lookups so decode reads see pending writes.

Parameters:
- XLEN, 64, datapath width; must equal register file width.
- DEPTH, 2, writeback FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  input  1  MEM stage presents a completed instruction.
- in_ready  output  1  stage can accept; equals (count < DEPTH).
- in_rd  input  5  destination register.
- in_reg_write  input  1  instruction writes rd.
- in_mem_to_reg  input  1  1 = load data, 0 = ALU result.
- in_funct3  input  3  load size: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU.
- in_alu_result  input  XLEN  ALU result.
- in_load_data  input  XLEN  raw doubleword from memory; bytes already aligned to bit 0.
- wb_stall  input  1  blocks pops from the FIFO this cycle.
- regWrite  output  1  register file write enable; registered.
- writeReg  output  5  register file write address; registered.
- writeData  output  XLEN  register file write data; registered.
- fwd_rs1, fwd_rs2  input  5 each  decode read addresses.
- fwd_hit1, fwd_hit2  output  1 each  a pending write targets the address.
- fwd_data1, fwd_data2  output  XLEN each  forwarded value.

Behaviour:
- Reset (reset=0, async): count=0, read/write pointers=0, regWrite=0, writeReg=0, writeData=0. Buffered entries are discarded; in_ready=1 once reset releases.
- Push: occurs when in_valid && in_ready.
  - Result formatting is combinational at push: in_mem_to_reg=0 takes in_alu_result; otherwise bits extracted per in_funct3.
  - Sign-extend for 000/001/010; zero-extend for 100/101/110; 011 passes all 64 bits.
  - funct3 111 is treated as 011.
- Stored entry: {we = in_reg_write && (in_rd != 0), rd, data}. Writes to x0 are kept in the FIFO but marked we=0.
- Pop: occurs when count>0 && !wb_stall.
  - At that edge: regWrite <= head.we, writeReg <= head.rd, writeData <= head.data.
  - With no pop: regWrite <= 0; writeReg and writeData hold their values.
- Latency: push at edge N, with empty FIFO and no stall → regWrite high during cycle N+1 → register file updated at edge N+2.
  - Sustained throughput: one instruction per cycle.
- Simultaneous push and pop: allowed whenever in_ready=1; count is unchanged.
- Full FIFO: in_ready=0, so no push occurs even if a pop happens in the same cycle (no pass-through).
- Pointer wrap: pointers wrap modulo DEPTH.
- Forwarding (combinational, independent per port): candidates are the output register (if regWrite=1) plus all valid FIFO entries with we=1.
  - Youngest matching entry wins; the output register is the oldest candidate.
  - Address 0 never hits. No hit → fwd_data=0.
- wb_stall while empty: no effect.
- Reset mid-operation: pending writes are lost; regWrite drops immediately.

Optional Feature:
- WB_PERF_CNT_EN defined:
  - Adds outputs perf_retired (64-bit; increments on each pop with we=1) and perf_stall (64-bit; increments each cycle with count>0 && wb_stall).
  - Both counters clear on reset and wrap at 2^64.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - XLEN default and REG_ADDR_W=5.
  - funct3 load-size constants (F3_LB … F3_LWU).
  - Packed wb_entry typedef {we, rd, data}.
- Natural sub-module: load_extend (combinational funct3-driven extractor/extender), reusable by the MEM stage.

Test Plan:
- Load sign handling: ALU push rd=5 data=0x1234 → regWrite=1, writeReg=5, writeData=0x1234 in the cycle after push. LB with load_data=0x...0080 → writeData=0xFFFFFFFFFFFFFF80. LBU with the same data → 0x80.
- Stall and backpressure: wb_stall=1 and 3 pushes attempted with DEPTH=2 → 2 accepted, in_ready=0 on the third. Release the stall → writes rd=1 then rd=2 on consecutive cycles, then the third push is accepted.
- x0 suppression: push rd=0, reg_write=1, data=0xDEAD → popped with regWrite=0. fwd_rs1=0 → fwd_hit1=0.
- Forwarding priority: with stall asserted, push rd=7 data=1 then rd=7 data=2 → fwd_rs1=7 gives hit=1, data=2. After the first pop → data=2 still. After both pops, while regWrite is still high → data=2.
- Reset mid-operation: FIFO holds 2 entries, reset pulsed low between edges → regWrite=0, in_ready=1 immediately, and no further writes after release.
- Back-to-back throughput: 10 consecutive pushes with no stall → 10 consecutive regWrite cycles, in_ready stays 1, and simultaneous push/pop keeps count at 1.
